// File: rtl/bus_switch_pkg.sv
// Shared MUSB switch definitions: FSM encodings, default watchdog limit, index-width helpers.
// Pure declarations; no latency or backpressure of its own.
package bus_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DERR   = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index fields are kept at least one bit wide so single-port builds stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_switch_if.sv
// MUSB interconnect signal bundle: per-master request/response lanes plus the shared slave-side bus.
// Wires only; timing and backpressure are set by whoever drives each modport.
interface bus_switch_if #(
  parameter int NMASTERS = 2,
  parameter int NSLAVES  = 2,
  parameter int DW       = 32,
  parameter int AW       = 32
);

  logic [NMASTERS*AW-1:0]     master_address;
  logic [NMASTERS*DW-1:0]     master_data_i;
  logic [NMASTERS*(DW/8)-1:0] master_wr;
  logic [NMASTERS-1:0]        master_enable;
  logic [NMASTERS*DW-1:0]     master_data_o;
  logic [NMASTERS-1:0]        master_ready;
  logic [NMASTERS-1:0]        master_error;

  logic [NSLAVES*DW-1:0]      slave_data_i;
  logic [NSLAVES-1:0]         slave_ready;
  logic [NSLAVES-1:0]         slave_error;
  logic [AW-1:0]              slave_address;
  logic [DW-1:0]              slave_data_o;
  logic [DW/8-1:0]            slave_wr;
  logic [NSLAVES-1:0]         slave_enable;

  modport master (
    output master_address, master_data_i, master_wr, master_enable,
    input  master_data_o, master_ready, master_error
  );

  modport slave (
    input  slave_address, slave_data_o, slave_wr, slave_enable,
    output slave_data_i, slave_ready, slave_error
  );

  modport sw (
    input  master_address, master_data_i, master_wr, master_enable,
    output master_data_o, master_ready, master_error,
    input  slave_data_i, slave_ready, slave_error,
    output slave_address, slave_data_o, slave_wr, slave_enable
  );

endinterface

// File: rtl/bus_switch_rr_arbiter.sv
// Round-robin pick of the first requester strictly after 'last', wrapping upward.
// Purely combinational; requests are never acknowledged here, only indexed.
module rr_arbiter
  import bus_switch_pkg::*;
#(
  parameter  int N  = 2,
  localparam int LW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          valid
);

  logic [LW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    valid   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = LW'((int'(last) + i) % N);
      if (!valid && req[cand]) begin
        valid   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_switch.sv
// NMASTERS x NSLAVES MUSB switch: round-robin arbitration, lowest-index address decode, watchdog.
// One cycle added latency; one IDLE cycle between transactions; unserved masters hold enable and wait.
module bus_switch
  import bus_switch_pkg::*;
#(
  parameter int                    NMASTERS   = 2,
  parameter int                    NSLAVES    = 2,
  parameter int                    DW         = 32,
  parameter int                    AW         = 32,
  parameter logic [NSLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NSLAVES*AW-1:0] MATCH_MASK = '0,
  parameter int                    TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic     clk,
  input  logic     rst_n,
  bus_switch_if.sw bus
);

  localparam int MW = idx_w(NMASTERS);
  localparam int SW = idx_w(NSLAVES);
  localparam int BW = DW / 8;

  state_e          state_q, state_d;
  logic [MW-1:0]   grant_q, grant_d;
  logic [MW-1:0]   last_q, last_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [MW-1:0]   arb_idx;
  logic            arb_vld;
  logic [AW-1:0]   req_addr;
  logic            hit;
  logic [SW-1:0]   hit_idx;

  logic [NMASTERS-1:0] rdy, err;
  logic [NSLAVES-1:0]  sen;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdat;
  logic [BW-1:0]       s_wr;

  rr_arbiter #(.N(NMASTERS)) u_arb (
    .req     (bus.master_enable),
    .last    (last_q),
    .gnt_idx (arb_idx),
    .valid   (arb_vld)
  );

  assign req_addr = bus.master_address[arb_idx*AW +: AW];

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int s = NSLAVES - 1; s >= 0; s--) begin
      if ((req_addr & MATCH_MASK[s*AW +: AW]) == MATCH_ADDR[s*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = SW'(s);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= MW'(NMASTERS - 1);
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdy     = '0;
    err     = '0;
    sen     = '0;
    s_addr  = '0;
    s_wdat  = '0;
    s_wr    = '0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          last_d  = arb_idx;
          sel_d   = hit ? hit_idx : '0;
          cnt_d   = '0;
          state_d = hit ? ACTIVE : DERR;
        end
      end
      ACTIVE: begin
        sen[sel_q] = 1'b1;
        s_addr     = bus.master_address[grant_q*AW +: AW];
        s_wdat     = bus.master_data_i[grant_q*DW +: DW];
        s_wr       = bus.master_wr[grant_q*BW +: BW];
        // A master dropping enable abandons the transfer silently.
        if (!bus.master_enable[grant_q]) begin
          state_d = IDLE;
        end else if (bus.slave_error[sel_q]) begin
          err[grant_q] = 1'b1;
          state_d      = IDLE;
        end else if (bus.slave_ready[sel_q]) begin
          rdy[grant_q] = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err[grant_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DERR: begin
        err[grant_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.master_ready  = rdy;
  assign bus.master_error  = err;
  assign bus.master_data_o = {NMASTERS{bus.slave_data_i[sel_q*DW +: DW]}};
  assign bus.slave_enable  = sen;
  assign bus.slave_address = s_addr;
  assign bus.slave_data_o  = s_wdat;
  assign bus.slave_wr      = s_wr;

endmodule

// File: tb/tb_bus_switch.sv
// Directed bench for bus_switch: 2 masters, 2 slaves (0x0xxx_xxxx, 0x1xxx_xxxx), TIMEOUT = 8.
module tb_bus_switch;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bus_switch_if #(.NMASTERS(NM), .NSLAVES(NS), .DW(DW), .AW(AW)) bus ();

  bus_switch #(
    .NMASTERS   (NM),
    .NSLAVES    (NS),
    .DW         (DW),
    .AW         (AW),
    .MATCH_ADDR ({32'h1000_0000, 32'h0000_0000}),
    .MATCH_MASK ({32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.master_address[m*AW +: AW] = a;
    bus.master_data_i[m*DW +: DW]  = d;
    bus.master_wr[m*4 +: 4]        = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n              = 1'b0;
    bus.master_address = '0;
    bus.master_data_i  = '0;
    bus.master_wr      = '0;
    bus.master_enable  = '0;
    bus.slave_ready    = '0;
    bus.slave_error    = '0;
    bus.slave_data_i   = {32'h2222_2222, 32'h1111_1111};

    #2;
    check("rst_sen",   bus.slave_enable, 2'b00);
    check("rst_rdy",   bus.master_ready, 2'b00);
    check("rst_err",   bus.master_error, 2'b00);
    check("rst_saddr", bus.slave_address, 32'h0);
    check("rst_rdata", bus.master_data_o, 64'h1111_1111_1111_1111);
    step();
    step();
    rst_n = 1'b1;

    // Simple read: M0 -> slave 0, answered in the first ACTIVE cycle.
    set_m(0, 32'h0000_0010, 32'h0, 4'h0);
    bus.master_enable = 2'b01;
    @(negedge clk);
    check("rd_idle_sen", bus.slave_enable, 2'b00);
    step();
    bus.slave_ready           = 2'b01;
    bus.slave_data_i[31:0]    = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rd_sen",   bus.slave_enable, 2'b01);
    check("rd_rdy",   bus.master_ready, 2'b01);
    check("rd_err",   bus.master_error, 2'b00);
    check("rd_rdata", bus.master_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
    check("rd_saddr", bus.slave_address, 32'h0000_0010);
    check("rd_swr",   bus.slave_wr, 4'h0);
    step();
    bus.master_enable = 2'b00;
    bus.slave_ready   = 2'b00;
    @(negedge clk);
    check("rd_done_sen", bus.slave_enable, 2'b00);
    check("rd_done_rdy", bus.master_ready, 2'b00);

    // Write: M1 -> slave 1, slave waits one cycle before ready.
    set_m(1, 32'h1000_0040, 32'hCAFE_0001, 4'hF);
    bus.master_enable = 2'b10;
    step();
    @(negedge clk);
    check("wr_sen",   bus.slave_enable, 2'b10);
    check("wr_saddr", bus.slave_address, 32'h1000_0040);
    check("wr_sdat",  bus.slave_data_o, 32'hCAFE_0001);
    check("wr_swr",   bus.slave_wr, 4'hF);
    check("wr_wait",  bus.master_ready, 2'b00);
    step();
    bus.slave_ready = 2'b10;
    @(negedge clk);
    check("wr_rdy",  bus.master_ready, 2'b10);
    check("wr_sen2", bus.slave_enable, 2'b10);
    step();
    bus.master_enable = 2'b00;
    bus.slave_ready   = 2'b00;
    @(negedge clk);
    check("wr_done_sen", bus.slave_enable, 2'b00);

    // Round-robin: both masters request continuously, slaves always ready.
    set_m(0, 32'h0000_0020, 32'h0, 4'h0);
    set_m(1, 32'h1000_0020, 32'h0, 4'h0);
    bus.master_enable = 2'b11;
    bus.slave_ready   = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      step();
      @(negedge clk);
      check($sformatf("rr_rdy_%0d", k), bus.master_ready,
            (k == 2 || k == 4) ? 2'b00 : (k == 3) ? 2'b10 : 2'b01);
      check($sformatf("rr_sen_%0d", k), bus.slave_enable,
            (k == 2 || k == 4) ? 2'b00 : (k == 3) ? 2'b10 : 2'b01);
    end
    step();
    bus.master_enable = 2'b00;
    bus.slave_ready   = 2'b00;

    // Decode error: M1 at 0x5000_0000 hits no slave.
    set_m(1, 32'h5000_0000, 32'h0, 4'h0);
    bus.master_enable = 2'b10;
    step();
    @(negedge clk);
    check("derr_err",   bus.master_error, 2'b10);
    check("derr_rdy",   bus.master_ready, 2'b00);
    check("derr_sen",   bus.slave_enable, 2'b00);
    check("derr_saddr", bus.slave_address, 32'h0);
    step();
    bus.master_enable = 2'b00;
    @(negedge clk);
    check("derr_done_err", bus.master_error, 2'b00);

    // Watchdog: slave 0 never answers, error in the 8th ACTIVE cycle.
    set_m(0, 32'h0000_0030, 32'h0, 4'h0);
    bus.master_enable = 2'b01;
    for (int k = 1; k <= TO; k++) begin
      step();
      @(negedge clk);
      check($sformatf("to_err_%0d", k), bus.master_error, (k == TO) ? 2'b01 : 2'b00);
      check($sformatf("to_sen_%0d", k), bus.slave_enable, 2'b01);
    end
    step();
    bus.master_enable = 2'b00;
    @(negedge clk);
    check("to_done_sen", bus.slave_enable, 2'b00);
    check("to_done_err", bus.master_error, 2'b00);

    // Ready and error together: error wins.
    set_m(1, 32'h1000_0000, 32'h0, 4'h0);
    bus.master_enable = 2'b10;
    step();
    bus.slave_ready = 2'b10;
    bus.slave_error = 2'b10;
    @(negedge clk);
    check("both_err", bus.master_error, 2'b10);
    check("both_rdy", bus.master_ready, 2'b00);
    step();
    bus.master_enable = 2'b00;
    bus.slave_ready   = 2'b00;
    bus.slave_error   = 2'b00;
    @(negedge clk);
    check("both_done_err", bus.master_error, 2'b00);

    // Abort: M0 drops enable while slave is ready; no response.
    set_m(0, 32'h0000_0040, 32'h0, 4'h0);
    bus.master_enable = 2'b01;
    step();
    @(negedge clk);
    check("abort_sen", bus.slave_enable, 2'b01);
    step();
    bus.master_enable = 2'b00;
    bus.slave_ready   = 2'b01;
    @(negedge clk);
    check("abort_rdy", bus.master_ready, 2'b00);
    check("abort_err", bus.master_error, 2'b00);
    step();
    bus.slave_ready = 2'b00;
    @(negedge clk);
    check("abort_done_sen", bus.slave_enable, 2'b00);

    // Reset mid-transaction (M0 last granted), then M0 must still win first.
    set_m(0, 32'h0000_0050, 32'h0, 4'h0);
    bus.master_enable = 2'b01;
    step();
    @(negedge clk);
    check("mrst_pre_sen", bus.slave_enable, 2'b01);
    #1;
    bus.slave_ready = 2'b01;
    rst_n           = 1'b0;
    #1;
    check("mrst_sen",   bus.slave_enable, 2'b00);
    check("mrst_rdy",   bus.master_ready, 2'b00);
    check("mrst_err",   bus.master_error, 2'b00);
    check("mrst_saddr", bus.slave_address, 32'h0);
    step();
    bus.slave_ready = 2'b00;
    set_m(1, 32'h1000_0050, 32'h0, 4'h0);
    bus.master_enable = 2'b11;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle_sen", bus.slave_enable, 2'b00);
    step();
    @(negedge clk);
    check("mrst_first_sen",   bus.slave_enable, 2'b01);
    check("mrst_first_saddr", bus.slave_address, 32'h0000_0050);
    step();
    bus.master_enable = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
